// File: rtl/cpu_pkg.sv
// Shared encodings for the writeback stage: ops, load sizes, FSM states, flag bits.
package cpu_pkg;

   typedef enum logic [2:0] {
      OP_NOP = 3'd0,
      OP_ALU = 3'd1,
      OP_CMP = 3'd2,
      OP_JMP = 3'd3,
      OP_LD  = 3'd4,
      OP_STR = 3'd5
   } op_e;

   typedef enum logic [1:0] {
      SZ_BYTE  = 2'd0,
      SZ_HALF  = 2'd1,
      SZ_WORD  = 2'd2,
      SZ_WORD3 = 2'd3
   } ld_size_e;

   typedef enum logic {
      ST_IDLE     = 1'b0,
      ST_WAIT_MEM = 1'b1
   } wb_state_e;

   // NZCV bit positions within the flag vector, N in the MSB
   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

endpackage

// File: rtl/wb_ld_align.sv
// Load lane extraction and zero/sign extension of returned memory data.
module wb_ld_align
   import cpu_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0] data,
   input  logic [1:0]        size,
   input  logic              signed_ld,
   input  logic [1:0]        off,
   output logic [DATA_W-1:0] value
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;

   // Pick the addressed lane, then extend it to the full register width
   always_comb begin
      byte_lane = data[{off, 3'b000} +: 8];
      half_lane = data[{off[1], 4'b0000} +: 16];
      value     = data;
      case (size)
         SZ_BYTE: value = {{(DATA_W-8){signed_ld & byte_lane[7]}}, byte_lane};
         SZ_HALF: value = {{(DATA_W-16){signed_ld & half_lane[15]}}, half_lane};
         default: value = data;
      endcase
   end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: retires ops into the register file / CPSR, waits for load data.
//
//  state       | meaning
//  ------------+-----------------------------------------------
//  ST_IDLE     | ready for a new op; non-LD ops retire next cycle
//  ST_WAIT_MEM | LD accepted, waiting for mem_rsp_valid
module wb_stage
   import cpu_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int REG_N  = 16,
   parameter int FLAG_W = 4,
   parameter int RA_W   = $clog2(REG_N)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        in_op,
   input  logic [RA_W-1:0]   in_rd_num,
   input  logic [DATA_W-1:0] in_result,
   input  logic [FLAG_W-1:0] in_flags,
   input  logic [1:0]        in_ld_size,
   input  logic              in_ld_signed,
   input  logic [1:0]        in_ld_off,
   input  logic              mem_rsp_valid,
   input  logic [DATA_W-1:0] mem_rsp_data,
   output logic              reg_we,
   output logic [RA_W-1:0]   reg_num,
   output logic [DATA_W-1:0] reg_value,
   output logic              cpsr_we,
   output logic [FLAG_W-1:0] cpsr_flags,
   output logic              retire,
   output logic [31:0]       retire_cnt,
   output logic              rsp_err
);

   wb_state_e         state, state_nxt;
   logic [RA_W-1:0]   ld_rd;
   logic [1:0]        ld_size;
   logic              ld_signed;
   logic [1:0]        ld_off;
   logic [DATA_W-1:0] ld_value;

   logic              accept;
   logic              wr_reg, wr_cpsr, ret_now, ld_capture, err_set;
   logic [RA_W-1:0]   num_d;
   logic [DATA_W-1:0] value_d;

   assign in_ready = (state == ST_IDLE);
   assign accept   = in_valid && in_ready;

   wb_ld_align #(.DATA_W(DATA_W)) u_align (
      .data      (mem_rsp_data),
      .size      (ld_size),
      .signed_ld (ld_signed),
      .off       (ld_off),
      .value     (ld_value)
   );

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   // Next state and the write/retire decisions for this edge
   always_comb begin
      state_nxt  = state;
      wr_reg     = 1'b0;
      wr_cpsr    = 1'b0;
      ret_now    = 1'b0;
      ld_capture = 1'b0;
      err_set    = 1'b0;
      num_d      = in_rd_num;
      value_d    = in_result;
      case (state)
         ST_IDLE: begin
            err_set = mem_rsp_valid;
            if (accept) begin
               case (in_op)
                  OP_ALU: begin wr_reg = 1'b1; wr_cpsr = 1'b1; ret_now = 1'b1; end
                  OP_JMP: begin wr_reg = 1'b1; ret_now = 1'b1; end
                  OP_CMP: begin wr_cpsr = 1'b1; ret_now = 1'b1; end
                  OP_STR: ret_now = 1'b1;
                  OP_LD: begin
                     ld_capture = 1'b1;
                     state_nxt  = ST_WAIT_MEM;
                  end
                  default: ;
               endcase
            end
         end
         ST_WAIT_MEM: begin
            num_d   = ld_rd;
            value_d = ld_value;
            if (mem_rsp_valid) begin
               wr_reg    = 1'b1;
               ret_now   = 1'b1;
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Output registers, load context capture and retire bookkeeping
   always_ff @(posedge clk) begin
      if (rst) begin
         reg_we     <= 1'b0;
         reg_num    <= '0;
         reg_value  <= '0;
         cpsr_we    <= 1'b0;
         cpsr_flags <= '0;
         retire     <= 1'b0;
         retire_cnt <= '0;
         rsp_err    <= 1'b0;
         ld_rd      <= '0;
         ld_size    <= '0;
         ld_signed  <= 1'b0;
         ld_off     <= '0;
      end else begin
         reg_we  <= wr_reg;
         cpsr_we <= wr_cpsr;
         retire  <= ret_now;
         if (wr_reg) begin
            reg_num   <= num_d;
            reg_value <= value_d;
         end
         if (wr_cpsr) cpsr_flags <= in_flags;
         if (ret_now) retire_cnt <= retire_cnt + 32'd1;
         if (err_set) rsp_err <= 1'b1;
         if (ld_capture) begin
            ld_rd     <= in_rd_num;
            ld_size   <= in_ld_size;
            ld_signed <= in_ld_signed;
            ld_off    <= in_ld_off;
         end
      end
   end

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage.
module tb_wb_stage;

   localparam int DATA_W = 32;
   localparam int REG_N  = 16;
   localparam int FLAG_W = 4;
   localparam int RA_W   = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic [2:0]        in_op;
   logic [RA_W-1:0]   in_rd_num;
   logic [DATA_W-1:0] in_result;
   logic [FLAG_W-1:0] in_flags;
   logic [1:0]        in_ld_size;
   logic              in_ld_signed;
   logic [1:0]        in_ld_off;
   logic              mem_rsp_valid;
   logic [DATA_W-1:0] mem_rsp_data;
   logic              reg_we;
   logic [RA_W-1:0]   reg_num;
   logic [DATA_W-1:0] reg_value;
   logic              cpsr_we;
   logic [FLAG_W-1:0] cpsr_flags;
   logic              retire;
   logic [31:0]       retire_cnt;
   logic              rsp_err;

   int total = 0;
   int bad   = 0;

   wb_stage #(.DATA_W(DATA_W), .REG_N(REG_N), .FLAG_W(FLAG_W)) dut (
      .clk           (clk),
      .rst           (rst),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_op         (in_op),
      .in_rd_num     (in_rd_num),
      .in_result     (in_result),
      .in_flags      (in_flags),
      .in_ld_size    (in_ld_size),
      .in_ld_signed  (in_ld_signed),
      .in_ld_off     (in_ld_off),
      .mem_rsp_valid (mem_rsp_valid),
      .mem_rsp_data  (mem_rsp_data),
      .reg_we        (reg_we),
      .reg_num       (reg_num),
      .reg_value     (reg_value),
      .cpsr_we       (cpsr_we),
      .cpsr_flags    (cpsr_flags),
      .retire        (retire),
      .retire_cnt    (retire_cnt),
      .rsp_err       (rsp_err)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      in_valid      = 1'b0;
      in_op         = 3'd0;
      in_rd_num     = '0;
      in_result     = '0;
      in_flags      = '0;
      in_ld_size    = 2'd0;
      in_ld_signed  = 1'b0;
      in_ld_off     = 2'd0;
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = '0;
   endtask

   task automatic do_reset();
      idle_in();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic put_op(input logic [2:0] op, input logic [3:0] rd,
                         input logic [31:0] res, input logic [3:0] fl);
      in_valid  = 1'b1;
      in_op     = op;
      in_rd_num = rd;
      in_result = res;
      in_flags  = fl;
   endtask

   task automatic put_ld(input logic [3:0] rd, input logic [1:0] sz,
                         input logic sg, input logic [1:0] off);
      put_op(3'd4, rd, 32'h0, 4'h0);
      in_ld_size   = sz;
      in_ld_signed = sg;
      in_ld_off    = off;
   endtask

   // one load with response after 'wait_n' idle cycles, checks the written value
   task automatic run_ld(input string tag, input logic [3:0] rd, input logic [1:0] sz,
                         input logic sg, input logic [1:0] off, input int wait_n,
                         input logic [31:0] data, input logic [31:0] exp);
      put_ld(rd, sz, sg, off);
      tick();
      idle_in();
      in_ld_size = 2'd3;
      in_ld_off  = 2'd1;
      for (int i = 0; i < wait_n; i++) begin
         chk({tag, "_ready_lo"}, in_ready, 1'b0);
         chk({tag, "_we_lo"}, reg_we, 1'b0);
         tick();
      end
      chk({tag, "_ready_wait"}, in_ready, 1'b0);
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = data;
      tick();
      mem_rsp_valid = 1'b0;
      chk({tag, "_we"}, reg_we, 1'b1);
      chk({tag, "_num"}, reg_num, rd);
      chk({tag, "_val"}, reg_value, exp);
      chk({tag, "_retire"}, retire, 1'b1);
      chk({tag, "_ready_back"}, in_ready, 1'b1);
   endtask

   initial begin
      rst = 1'b0;
      idle_in();
      tick();
      do_reset();
      chk("rst_ready", in_ready, 1'b1);
      chk("rst_we", reg_we, 1'b0);
      chk("rst_cwe", cpsr_we, 1'b0);
      chk("rst_retire", retire, 1'b0);
      chk("rst_num", reg_num, 0);
      chk("rst_val", reg_value, 0);
      chk("rst_flags", cpsr_flags, 0);
      chk("rst_cnt", retire_cnt, 0);
      chk("rst_err", rsp_err, 1'b0);

      // ALU write of reg and flags
      put_op(3'd1, 4'd3, 32'h1234_5678, 4'h4);
      tick();
      idle_in();
      chk("alu_we", reg_we, 1'b1);
      chk("alu_num", reg_num, 3);
      chk("alu_val", reg_value, 32'h1234_5678);
      chk("alu_cwe", cpsr_we, 1'b1);
      chk("alu_flags", cpsr_flags, 4'h4);
      chk("alu_retire", retire, 1'b1);
      chk("alu_cnt", retire_cnt, 1);

      // NOP and op 7: nothing written, outputs hold
      put_op(3'd0, 4'd9, 32'hDEAD_BEEF, 4'hF);
      tick();
      chk("nop_we", reg_we, 1'b0);
      chk("nop_retire", retire, 1'b0);
      chk("nop_hold_val", reg_value, 32'h1234_5678);
      put_op(3'd7, 4'd9, 32'hDEAD_BEEF, 4'hF);
      tick();
      idle_in();
      chk("op7_we", reg_we, 1'b0);
      chk("op7_cwe", cpsr_we, 1'b0);
      chk("op7_hold_num", reg_num, 3);
      chk("op7_hold_flags", cpsr_flags, 4'h4);
      chk("op7_cnt", retire_cnt, 1);

      // CMP then STR back-to-back
      do_reset();
      put_op(3'd2, 4'd7, 32'hAAAA_AAAA, 4'h9);
      tick();
      put_op(3'd5, 4'd8, 32'h5555_5555, 4'h1);
      chk("cmp_cwe", cpsr_we, 1'b1);
      chk("cmp_flags", cpsr_flags, 4'h9);
      chk("cmp_we", reg_we, 1'b0);
      chk("cmp_retire", retire, 1'b1);
      tick();
      idle_in();
      chk("str_retire", retire, 1'b1);
      chk("str_we", reg_we, 1'b0);
      chk("str_cwe", cpsr_we, 1'b0);
      chk("str_cnt", retire_cnt, 2);

      // back-to-back ALU/JMP, one retire per cycle
      put_op(3'd1, 4'd1, 32'h0000_0011, 4'h2);
      tick();
      put_op(3'd3, 4'd14, 32'h0000_2000, 4'hF);
      chk("b2b0_val", reg_value, 32'h11);
      chk("b2b0_flags", cpsr_flags, 4'h2);
      tick();
      put_op(3'd1, 4'd2, 32'hFFFF_0000, 4'h8);
      chk("b2b1_num", reg_num, 14);
      chk("b2b1_val", reg_value, 32'h2000);
      chk("b2b1_cwe", cpsr_we, 1'b0);
      chk("b2b1_ready", in_ready, 1'b1);
      tick();
      idle_in();
      chk("b2b2_num", reg_num, 2);
      chk("b2b2_flags", cpsr_flags, 4'h8);
      chk("b2b2_cnt", retire_cnt, 5);

      // loads: signed byte off 2, unsigned half, word, min latency
      do_reset();
      run_ld("ldb", 4'd5, 2'd0, 1'b1, 2'd2, 2, 32'h0080_0000, 32'hFFFF_FF80);
      chk("ldb_cnt", retire_cnt, 1);
      run_ld("ldbu", 4'd6, 2'd0, 1'b0, 2'd3, 0, 32'h9ABC_DEF0, 32'h0000_009A);
      run_ld("ldhu", 4'd7, 2'd1, 1'b0, 2'd2, 1, 32'hBEEF_1234, 32'h0000_BEEF);
      run_ld("ldhs", 4'd8, 2'd1, 1'b1, 2'd1, 0, 32'hBEEF_8234, 32'hFFFF_8234);
      run_ld("ldw", 4'd9, 2'd2, 1'b1, 2'd3, 3, 32'h8765_4321, 32'h8765_4321);
      run_ld("ldw3", 4'd10, 2'd3, 1'b0, 2'd2, 0, 32'hCAFE_F00D, 32'hCAFE_F00D);
      chk("ld_err", rsp_err, 1'b0);
      chk("ld_cnt", retire_cnt, 6);

      // stray response while idle
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = 32'h1111_1111;
      tick();
      idle_in();
      chk("stray_err", rsp_err, 1'b1);
      chk("stray_we", reg_we, 1'b0);
      chk("stray_val", reg_value, 32'hCAFE_F00D);
      tick();
      chk("stray_sticky", rsp_err, 1'b1);

      // response in the reset cycle is ignored
      rst = 1'b1;
      mem_rsp_valid = 1'b1;
      tick();
      rst = 1'b0;
      mem_rsp_valid = 1'b0;
      chk("rstrsp_err", rsp_err, 1'b0);

      // reset abandons a pending load
      put_ld(4'd4, 2'd2, 1'b0, 2'd0);
      tick();
      idle_in();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort_ready", in_ready, 1'b1);
      chk("abort_we0", reg_we, 1'b0);
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = 32'h7777_7777;
      tick();
      idle_in();
      chk("abort_we1", reg_we, 1'b0);
      chk("abort_err", rsp_err, 1'b1);
      chk("abort_cnt", retire_cnt, 0);
      chk("abort_val", reg_value, 0);

      // retire counter wrap via backdoor preload
      dut.retire_cnt = 32'hFFFF_FFFF;
      put_op(3'd5, 4'd0, 32'h0, 4'h0);
      tick();
      idle_in();
      chk("wrap_retire", retire, 1'b1);
      chk("wrap_cnt", retire_cnt, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
